// File: rtl/div32u_restoring_seq_if.sv
// Handshake bundle for the sequential unsigned divider: operand channel in, result channel out.
interface div32u_restoring_seq_if #(parameter int WIDTH = 16);
   logic                 in_valid;
   logic                 in_ready;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 div_by_zero;
   logic                 overflow;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/div32u_restoring_seq.sv
// Radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per cycle.
module div32u_restoring_seq #(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   div32u_restoring_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   dvs_q;
   logic [CW-1:0]      cnt;

   logic               out_valid_q;
   logic [WIDTH-1:0]   quotient_q;
   logic [WIDTH-1:0]   remainder_q;
   logic               dbz_q;
   logic               ovf_q;

   logic [WIDTH:0]     r_sh;
   logic [WIDTH:0]     r_nxt;
   logic               q_bit;

   // R stays below the divisor, so the shifted value always fits in WIDTH+1 bits.
   always_comb begin
      r_sh  = {rem_q[WIDTH-1:0], lo_q[WIDTH-1]};
      q_bit = (r_sh >= {1'b0, dvs_q});
      r_nxt = q_bit ? (r_sh - {1'b0, dvs_q}) : r_sh;
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.overflow    = ovf_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         lo_q        <= '0;
         dvs_q       <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.divisor == '0) begin
                     quotient_q  <= '1;
                     remainder_q <= bus.dividend[WIDTH-1:0];
                     dbz_q       <= 1'b1;
                     ovf_q       <= 1'b0;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end else if (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor) begin
                     // High half already >= divisor: quotient cannot fit in WIDTH bits.
                     quotient_q  <= '1;
                     remainder_q <= '0;
                     dbz_q       <= 1'b0;
                     ovf_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end else begin
                     rem_q <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
                     lo_q  <= bus.dividend[WIDTH-1:0];
                     dvs_q <= bus.divisor;
                     quo_q <= '0;
                     cnt   <= CW'(WIDTH - 1);
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               rem_q <= r_nxt;
               quo_q <= {quo_q[WIDTH-2:0], q_bit};
               lo_q  <= {lo_q[WIDTH-2:0], 1'b0};
               if (cnt == '0) begin
                  quotient_q  <= {quo_q[WIDTH-2:0], q_bit};
                  remainder_q <= r_nxt[WIDTH-1:0];
                  dbz_q       <= 1'b0;
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div32u_restoring_seq.sv
// Bench for div32u_restoring_seq: directed vector table, stall/reset sequences, random ops vs. arithmetic model.
module tb_div32u_restoring_seq;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div32u_restoring_seq_if #(.WIDTH(W)) bus();
   div32u_restoring_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] dd;
      logic [15:0] dv;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ov;
      int          lat;
      int          stall;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, saturating when the quotient exceeds 16 bits.
   function automatic void ref_div(input logic [31:0] dd, input logic [15:0] dv,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic dz, output logic ov, output int lat);
      logic [31:0] qq;
      if (dv == 16'd0) begin
         q = 16'hFFFF; r = dd[15:0]; dz = 1'b1; ov = 1'b0; lat = 1;
      end else begin
         qq = dd / {16'd0, dv};
         if (qq > 32'h0000_FFFF) begin
            q = 16'hFFFF; r = 16'd0; dz = 1'b0; ov = 1'b1; lat = 1;
         end else begin
            q = qq[15:0]; r = 16'(dd % {16'd0, dv}); dz = 1'b0; ov = 1'b0; lat = 17;
         end
      end
   endfunction

   // One full transaction; lat counts cycles from the accept edge to out_valid being seen.
   task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, input int stall,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov, output int lat);
      int  n;
      bit  stable;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_op", 32'(bus.in_ready), 32'd1);
      bus.dividend  = dd;
      bus.divisor   = dv;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = 16'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
      q  = bus.quotient;
      r  = bus.remainder;
      dz = bus.div_by_zero;
      ov = bus.overflow;
      if (stall > 0) begin
         stable = 1'b1;
         repeat (stall) begin
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (!bus.out_valid || bus.in_ready || bus.quotient !== q || bus.remainder !== r ||
                bus.div_by_zero !== dz || bus.overflow !== ov)
               stable = 1'b0;
         end
         chk("stall_stable", 32'(stable), 32'd1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("consume_out_valid", 32'(bus.out_valid), 32'd0);
      chk("consume_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] q, r, eq, er, dv, hi;
      logic        dz, ov, edz, eov;
      logic [31:0] dd;
      int          lat, elat, sel, n;

      vecs[0] = '{32'h0000_0063, 16'h0007, 16'h000E, 16'h0001, 1'b0, 1'b0, 17, 0};
      vecs[1] = '{32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 0};
      vecs[2] = '{32'h0000_1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1,  0};
      vecs[3] = '{32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1,  0};
      vecs[4] = '{32'h0000_0063, 16'h0007, 16'h000E, 16'h0001, 1'b0, 1'b0, 17, 5};
      vecs[5] = '{32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 17, 0};
      vecs[6] = '{32'h0007_0000, 16'h0007, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1,  3};
      vecs[7] = '{32'h0000_FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17, 0};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_quotient", 32'(bus.quotient), 32'd0);
      chk("reset_remainder", 32'(bus.remainder), 32'd0);
      chk("reset_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].dd, vecs[i].dv, vecs[i].stall, q, r, dz, ov, lat);
         chk($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
         chk($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
         chk($sformatf("vec%0d_div_by_zero", i), 32'(dz), 32'(vecs[i].dz));
         chk($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].ov));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Reset in the middle of a running division: the result must never appear.
      @(negedge clk);
      bus.dividend = 32'h1234_5678;
      bus.divisor  = 16'hABCD;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrun_reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrun_reset_out_valid", 32'(bus.out_valid), 32'd0);
      n = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.out_valid) n++;
      end
      chk("midrun_reset_no_result", 32'(n), 32'd0);
      run_op(32'd99, 16'd7, 0, q, r, dz, ov, lat);
      chk("post_reset_quotient", 32'(q), 32'd14);
      chk("post_reset_remainder", 32'(r), 32'd1);
      chk("post_reset_latency", 32'(lat), 32'd17);

      // Random operands, mostly in-range, with occasional zero divisors and overflows.
      for (int k = 0; k < 2000; k++) begin
         sel = int'($urandom_range(15, 0));
         dv  = (sel == 0) ? 16'd0 : 16'($urandom_range(65535, 1));
         if (dv == 16'd0)    hi = 16'($urandom);
         else if (sel == 1)  hi = 16'($urandom_range(65535, int'(dv)));
         else                hi = 16'($urandom % {16'd0, dv});
         dd = {hi, 16'($urandom)};
         ref_div(dd, dv, eq, er, edz, eov, elat);
         run_op(dd, dv, int'($urandom_range(2, 0)), q, r, dz, ov, lat);
         chk("rand_quotient", 32'(q), 32'(eq));
         chk("rand_remainder", 32'(r), 32'(er));
         chk("rand_flags", {30'd0, dz, ov}, {30'd0, edz, eov});
         chk("rand_latency", 32'(lat), 32'(elat));
         if (!edz && !eov) begin
            chk("rand_invariant", {16'd0, q} * {16'd0, dv} + {16'd0, r}, dd);
            chk("rand_rem_lt_div", 32'(r < dv), 32'd1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
